// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//
// Sequential shift-and-add multiplier. One N-bit adder with carry-in is shared
// by every arithmetic step: the partial-product adds during CALC, and (signed
// build only) the operand negation on the start cycle and the final two-step
// product negation.
//
// Ports
//   clk_i    in   1    clock, all state changes on the rising edge
//   rst_i    in   1    synchronous active-high reset, wins over start_i
//   start_i  in   1    begin a multiply; only honoured while ready_o=1
//   a_i      in   N    multiplicand, captured on the accepted start
//   b_i      in   N    multiplier, captured on the accepted start
//   ready_o  out  1    high only while idle
//   done_o   out  1    one-cycle pulse when p_o holds the new product
//   p_o      out  2N   product, stable from done_o until the next accepted start
//
// Configuration
//   SIGNED_MULT_EN  when defined, a_i/b_i are two's complement and p_o is the
//                   signed product; when undefined the multiply is unsigned.
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
  parameter int N = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           ready_o,
  output logic           done_o,
  output logic [2*N-1:0] p_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CALC   = 3'd1;
  localparam logic [2:0] S_DONE   = 3'd2;
`ifdef SIGNED_MULT_EN
  localparam logic [2:0] S_NEG_LO = 3'd3;
  localparam logic [2:0] S_NEG_HI = 3'd4;
`endif

  // The cycle counter is a thermometer code: one more 1 shifts in per CALC
  // cycle, so the count value is the number of ones and no incrementer is
  // needed next to the single shared adder.
  localparam logic [N-2:0] CNT_ONE = (N-1)'(1);

  logic [2:0]   r_state;
  logic [N-1:0] r_mcand;
  logic [N-1:0] r_mplier;
  logic [N-1:0] r_accHi;
  logic [N-1:0] r_accLo;
  logic [N-2:0] r_count;

`ifdef SIGNED_MULT_EN
  logic         r_sign;
  logic         r_nonZero;
  logic         r_bNeg;
  logic         r_seenOne;
  logic         r_negCarry;
`endif

  logic [N-1:0] w_addA;
  logic [N-1:0] w_addB;
  logic         w_cin;
  logic [N-1:0] w_sum;
  logic         w_cout;
  logic         w_mBit;

  assign ready_o = (r_state == S_IDLE);
  assign done_o  = (r_state == S_DONE);
  assign p_o     = {r_accHi, r_accLo};

  // Effective multiplier bit for this CALC cycle. In the signed build a
  // negative multiplier is negated bit-serially as it shifts out: each bit of
  // -b equals b[i] XOR (any 1 seen below bit i), which yields the magnitude
  // without spending the adder on the start cycle a second time.
`ifdef SIGNED_MULT_EN
  assign w_mBit = r_bNeg ? (r_mplier[0] ^ r_seenOne) : r_mplier[0];
`else
  assign w_mBit = r_mplier[0];
`endif

  // Operand steering for the one shared adder. CALC adds the multiplicand
  // (or zero) to the high accumulator half; the signed states reuse the same
  // adder as ~x + 0 + cin to form two's complement negations.
  always_comb begin
    w_addA = r_accHi;
    w_addB = '0;
    w_cin  = 1'b0;
    case (r_state)
      S_CALC: begin
        w_addB = w_mBit ? r_mcand : '0;
      end
`ifdef SIGNED_MULT_EN
      S_IDLE: begin
        w_addA = ~a_i;
        w_cin  = 1'b1;
      end
      S_NEG_LO: begin
        w_addA = ~r_accLo;
        w_cin  = 1'b1;
      end
      S_NEG_HI: begin
        w_addA = ~r_accHi;
        w_cin  = r_negCarry;
      end
`endif
      default: begin
      end
    endcase
  end

  // The shared adder itself: N-bit sum plus carry-out.
  assign {w_cout, w_sum} = {1'b0, w_addA} + {1'b0, w_addB} + {{N{1'b0}}, w_cin};

  // Control FSM and datapath registers. Each CALC cycle shifts
  // {cout, sum, acc_lo} right by one, so the final carry lands in the MSB of
  // the high half and the product never overflows 2N bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_accHi    <= '0;
      r_accLo    <= '0;
      r_count    <= '0;
`ifdef SIGNED_MULT_EN
      r_sign     <= 1'b0;
      r_nonZero  <= 1'b0;
      r_bNeg     <= 1'b0;
      r_seenOne  <= 1'b0;
      r_negCarry <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
`ifdef SIGNED_MULT_EN
            // Multiplicand magnitude comes from the adder (~a + 1); the
            // most negative value maps onto 2^(N-1), which still fits N bits.
            r_mcand    <= a_i[N-1] ? w_sum : a_i;
            r_sign     <= a_i[N-1] ^ b_i[N-1];
            r_nonZero  <= (|a_i) & (|b_i);
            r_bNeg     <= b_i[N-1];
            r_seenOne  <= 1'b0;
            r_negCarry <= 1'b0;
`else
            r_mcand    <= a_i;
`endif
            r_mplier   <= b_i;
            r_accHi    <= '0;
            r_accLo    <= '0;
            r_count    <= '0;
            r_state    <= S_CALC;
          end
        end

        S_CALC: begin
          r_accHi  <= {w_cout, w_sum[N-1:1]};
          r_accLo  <= {w_sum[0], r_accLo[N-1:1]};
          r_mplier <= r_mplier >> 1;
`ifdef SIGNED_MULT_EN
          r_seenOne <= r_seenOne | r_mplier[0];
`endif
          if (r_count[N-2]) begin
            r_count <= '0;
`ifdef SIGNED_MULT_EN
            // A zero product skips negation so it keeps the short latency.
            r_state <= (r_sign & r_nonZero) ? S_NEG_LO : S_DONE;
`else
            r_state <= S_DONE;
`endif
          end else begin
            r_count <= (r_count << 1) | CNT_ONE;
          end
        end

`ifdef SIGNED_MULT_EN
        S_NEG_LO: begin
          r_accLo    <= w_sum;
          r_negCarry <= w_cout;
          r_state    <= S_NEG_HI;
        end

        S_NEG_HI: begin
          r_accHi <= w_sum;
          r_state <= S_DONE;
        end
`endif

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
//
// Directed self-checking bench for mult_seq_ctrl with N=8. Each scenario task
// drives its own stimulus and compares against hand-computed values. Latency
// is counted in rising edges after the edge that accepts start_i, so a done_o
// in cycle t+N+1 shows up as latency N.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           done;
  logic [2*N-1:0] p;

  int testsRun    = 0;
  int testsFailed = 0;

  mult_seq_ctrl #(.N(N)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .ready_o (ready),
    .done_o  (done),
    .p_o     (p)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the scenario sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Launch one multiply from IDLE and wait (bounded) for done_o. Reports the
  // latency in edges after acceptance (-1 on timeout), the product seen with
  // done_o, and whether ready_o stayed low from acceptance through done_o.
  task automatic applyStimulus(input logic [N-1:0] aIn, input logic [N-1:0] bIn,
                               output int lat, output logic [2*N-1:0] prod,
                               output logic readyLow);
    lat      = -1;
    prod     = '0;
    readyLow = 1'b1;
    @(negedge clk);
    start = 1'b1;
    a     = aIn;
    b     = bIn;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ready !== 1'b0) readyLow = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b0) readyLow = 1'b0;
      if (done === 1'b1) begin
        lat  = k;
        prod = p;
        break;
      end
    end
  endtask

  // Reset values, and reset winning over a simultaneous start.
  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: got %b expected 1", ready);
    end
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    testsRun++;
    if (p !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_p: got %h expected 0000", p);
    end
    @(negedge clk);
    start = 1'b1;
    a     = 8'd3;
    b     = 8'd3;
    @(posedge clk);
    #1;
    testsRun++;
    if (ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_priority_ready: got %b expected 1", ready);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    testsRun++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_priority_idle: got ready=%b done=%b expected ready=1 done=0",
               ready, done);
    end
  endtask

  // 13 x 11: latency, product, ready_o profile, and return to IDLE.
  task automatic test_basic;
    int             lat;
    logic [2*N-1:0] prod;
    logic           readyLow;
    testsRun++;
    if (ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL basic_ready_before: got %b expected 1", ready);
    end
    applyStimulus(8'd13, 8'd11, lat, prod, readyLow);
    testsRun++;
    if (lat !== N) begin
      testsFailed++;
      $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, N);
    end
    testsRun++;
    if (prod !== 16'h008F) begin
      testsFailed++;
      $display("[TB] FAIL basic_product: got %h expected 008f", prod);
    end
    testsRun++;
    if (readyLow !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL basic_ready_busy: got %b expected 1", readyLow);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_after_done: got ready=%b done=%b expected ready=1 done=0",
               ready, done);
    end
    testsRun++;
    if (p !== 16'h008F) begin
      testsFailed++;
      $display("[TB] FAIL basic_hold: got %h expected 008f", p);
    end
  endtask

  // Boundary operands: all-ones, zero on either side, one, power of two.
  task automatic test_corners;
    logic [N-1:0]   va  [5] = '{8'd255, 8'd0,   8'd200, 8'd1, 8'd128};
    logic [N-1:0]   vb  [5] = '{8'd255, 8'd200, 8'd0,   8'd1, 8'd2};
    logic [2*N-1:0] exp [5] = '{16'hFE01, 16'h0000, 16'h0000, 16'h0001, 16'h0100};
    int             lat;
    logic [2*N-1:0] prod;
    logic           readyLow;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(va[i], vb[i], lat, prod, readyLow);
      testsRun++;
      if (lat !== N) begin
        testsFailed++;
        $display("[TB] FAIL corner_latency[%0d]: got %0d expected %0d", i, lat, N);
      end
      testsRun++;
      if (prod !== exp[i]) begin
        testsFailed++;
        $display("[TB] FAIL corner_product[%0d]: got %h expected %h", i, prod, exp[i]);
      end
      @(posedge clk);
    end
  endtask

  // Starts during CALC and during the DONE cycle are dropped, operand changes
  // during CALC are ignored, and the product holds afterwards.
  task automatic test_ignored_start;
    int             dones   = 0;
    int             lat     = -1;
    logic [2*N-1:0] prod    = '0;
    @(negedge clk);
    start = 1'b1;
    a     = 8'd13;
    b     = 8'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'd200;
    b     = 8'd3;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dones++;
        if (lat < 0) begin
          lat  = k;
          prod = p;
        end
      end
      @(negedge clk);
      start = (k == 3 || k == 8) ? 1'b1 : 1'b0;
    end
    testsRun++;
    if (dones !== 1) begin
      testsFailed++;
      $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones);
    end
    testsRun++;
    if (lat !== N) begin
      testsFailed++;
      $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, N);
    end
    testsRun++;
    if (prod !== 16'h008F) begin
      testsFailed++;
      $display("[TB] FAIL ignore_product: got %h expected 008f", prod);
    end
    testsRun++;
    if (p !== 16'h008F || ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ignore_hold: got p=%h ready=%b expected p=008f ready=1", p, ready);
    end
  endtask

  // Reset in the middle of CALC abandons the multiply without a done_o.
  task automatic test_reset_mid;
    int             dones = 0;
    int             lat;
    logic [2*N-1:0] prod;
    logic           readyLow;
    @(negedge clk);
    start = 1'b1;
    a     = 8'd13;
    b     = 8'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (ready !== 1'b1 || p !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL midreset_state: got ready=%b p=%h expected ready=1 p=0000", ready, p);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    testsRun++;
    if (dones !== 0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_no_done: got %0d expected 0", dones);
    end
    applyStimulus(8'd7, 8'd9, lat, prod, readyLow);
    testsRun++;
    if (lat !== N || prod !== 16'd63) begin
      testsFailed++;
      $display("[TB] FAIL midreset_recover: got lat=%0d p=%h expected lat=%0d p=003f",
               lat, prod, N);
    end
    @(posedge clk);
  endtask

  // start held high: results arrive every N+2 cycles, and operands presented
  // during DONE are the ones captured by the next accepted start.
  task automatic test_back_to_back;
    int             first  = -1;
    int             second = -1;
    logic [2*N-1:0] p1     = '0;
    logic [2*N-1:0] p2     = '0;
    @(negedge clk);
    start = 1'b1;
    a     = 8'd5;
    b     = 8'd6;
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (first < 0) begin
          first = k;
          p1    = p;
          a     = 8'd9;
          b     = 8'd4;
        end else if (second < 0) begin
          second = k;
          p2     = p;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    testsRun++;
    if (first !== N) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", first, N);
    end
    testsRun++;
    if (second - first !== N + 2) begin
      testsFailed++;
      $display("[TB] FAIL b2b_interval: got %0d expected %0d", second - first, N + 2);
    end
    testsRun++;
    if (p1 !== 16'd30 || p2 !== 16'd36) begin
      testsFailed++;
      $display("[TB] FAIL b2b_products: got %h,%h expected 001e,0024", p1, p2);
    end
  endtask

`ifdef SIGNED_MULT_EN
  // Signed products: negative results take two extra negation cycles.
  task automatic test_signed;
    logic [N-1:0]   va   [5] = '{8'hFD, 8'h80, 8'h80, 8'h05, 8'hFD};
    logic [N-1:0]   vb   [5] = '{8'h07, 8'h80, 8'h01, 8'hFC, 8'h00};
    logic [2*N-1:0] exp  [5] = '{16'hFFEB, 16'h4000, 16'hFF80, 16'hFFEC, 16'h0000};
    int             expL [5] = '{N + 2, N, N + 2, N + 2, N};
    int             lat;
    logic [2*N-1:0] prod;
    logic           readyLow;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(va[i], vb[i], lat, prod, readyLow);
      testsRun++;
      if (lat !== expL[i]) begin
        testsFailed++;
        $display("[TB] FAIL signed_latency[%0d]: got %0d expected %0d", i, lat, expL[i]);
      end
      testsRun++;
      if (prod !== exp[i]) begin
        testsFailed++;
        $display("[TB] FAIL signed_product[%0d]: got %h expected %h", i, prod, exp[i]);
      end
      @(posedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
`ifdef SIGNED_MULT_EN
    test_signed();
`else
    test_corners();
`endif
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
